sub_4b_core: RTL and testbench



---
 rtl/sub_pkg.sv | 11 +
 rtl/sub_1b.sv | 11 +
 rtl/sub_4b_core.sv | 63 ++++++
 tb/tb_sub_4b_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared width and flag definitions for the 4-bit subtract leaf.
package sub_pkg;
    localparam int SUB_W = 4;

    typedef struct packed {
        logic borrow;
        logic ovf;
        logic zero;
        logic neg;
    } sub_flags_t;
endpackage

// File: rtl/sub_1b.sv
// One full-subtractor cell: d = a - b - bin, with borrow out.
module sub_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub_4b_core.sv
// Registered 4-bit subtractor (x - y mod 16) with borrow/overflow/zero/neg flags.
module sub_4b_core
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SUB_W-1:0] x,
    input  logic [SUB_W-1:0] y,
    output logic [SUB_W-1:0] out,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             out_valid
);
    logic [SUB_W:0]   w_b;
    logic [SUB_W-1:0] w_d;
    sub_flags_t       w_flags;

    logic [SUB_W-1:0] r_out;
    sub_flags_t       r_flags;
    logic             r_valid;

    assign w_b[0] = 1'b0;

    for (genvar i = 0; i < SUB_W; i++) begin : g_cell
        sub_1b u_cell (
            .a    (x[i]),
            .b    (y[i]),
            .bin  (w_b[i]),
            .d    (w_d[i]),
            .bout (w_b[i+1])
        );
    end

    assign w_flags.borrow = w_b[SUB_W];
    assign w_flags.ovf    = (x[SUB_W-1] ^ y[SUB_W-1]) & (w_d[SUB_W-1] ^ x[SUB_W-1]);
    assign w_flags.zero   = (w_d == '0);
    assign w_flags.neg    = w_d[SUB_W-1];

    // Result/flags load only on in_valid so idle (possibly X) operands never reach state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_flags <= '{borrow: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out   <= w_d;
                r_flags <= w_flags;
            end
        end
    end

    assign out       = r_out;
    assign borrow    = r_flags.borrow;
    assign ovf       = r_flags.ovf;
    assign zero      = r_flags.zero;
    assign neg       = r_flags.neg;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_sub_4b_core.sv
// Scoreboard bench for sub_4b_core: expected results queued at drive time, compared one cycle later.
module tb_sub_4b_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] x = 4'd0;
    logic [3:0] y = 4'd0;
    logic [3:0] out;
    logic       borrow, ovf, zero, neg, out_valid;

    typedef struct packed {
        logic [3:0] d;
        logic       b;
        logic       o;
        logic       z;
        logic       n;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t last;
    int   total = 0;
    int   bad   = 0;

    sub_4b_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .out       (out),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t r;
        int ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        sd = sa - sb;
        r.d = 4'((ua - ub + 16) % 16);
        r.b = (ua < ub);
        r.o = (sd > 7) || (sd < -8);
        r.z = (r.d == 4'd0);
        r.n = r.d[3];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out, borrow, ovf, zero, neg, out_valid} !== {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got out=%b b=%b o=%b z=%b n=%b v=%b want out=0000 b=0 o=0 z=1 n=0 v=0",
                     out, borrow, ovf, zero, neg, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] tbl [4];
        tbl[0] = 8'b1000_0000;
        tbl[1] = 8'b1000_1001;
        tbl[2] = 8'b1101_1001;
        tbl[3] = 8'b1101_0110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = tbl[i][7:4];
            y = tbl[i][3:0];
            q.push_back(model(x, y));
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL directed%0d_valid: got %b want 1", i, out_valid);
            end
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL directed%0d_sb: got empty queue want entry", i);
            end else begin
                e = q.pop_front();
                last = e;
                if ({out, borrow, ovf, zero, neg} !== e) begin
                    bad++;
                    $display("FAIL directed%0d: got out=%b b=%b o=%b z=%b n=%b want out=%b b=%b o=%b z=%b n=%b",
                             i, out, borrow, ovf, zero, neg, e.d, e.b, e.o, e.z, e.n);
                end
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            x = (i == 0) ? 4'bxxxx : 4'($urandom_range(0, 15));
            y = (i == 0) ? 4'bzzzz : 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            total++;
            if ({out, borrow, ovf, zero, neg, out_valid} !== {last, 1'b0}) begin
                bad++;
                $display("FAIL hold%0d: got out=%b b=%b o=%b z=%b n=%b v=%b want out=%b b=%b o=%b z=%b n=%b v=0",
                         i, out, borrow, ovf, zero, neg, out_valid, last.d, last.b, last.o, last.z, last.n);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        x = 4'b0101;
        y = 4'b0101;
        q.push_back(model(x, y));
        @(posedge clk);
        #1;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL equal_sb: got empty queue want entry");
        end else begin
            e = q.pop_front();
            if ({out, borrow, ovf, zero, neg, out_valid} !== {e, 1'b1}) begin
                bad++;
                $display("FAIL equal: got out=%b b=%b o=%b z=%b n=%b v=%b want out=0000 z=1 others 0 v=1",
                         out, borrow, ovf, zero, neg, out_valid);
            end
        end
    endtask

    task automatic test_rst_collision();
        @(negedge clk);
        in_valid = 1'b1;
        x = 4'b1111;
        y = 4'b0001;
        q.push_back(model(x, y));
        @(posedge clk);
        #1;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL pre_rst_sb: got empty queue want entry");
        end else begin
            e = q.pop_front();
            if ({out, borrow, ovf, zero, neg} !== e) begin
                bad++;
                $display("FAIL pre_rst: got out=%b want out=%b", out, e.d);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        x = 4'b0011;
        y = 4'b0001;
        @(posedge clk);
        #1;
        total++;
        if ({out, borrow, ovf, zero, neg, out_valid} !== {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_collision: got out=%b b=%b o=%b z=%b n=%b v=%b want out=0000 z=1 v=0",
                     out, borrow, ovf, zero, neg, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({out, zero, out_valid} !== {4'b0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL post_rst_idle: got out=%b z=%b v=%b want out=0000 z=1 v=0", out, zero, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            q.push_back(model(x, y));
            @(posedge clk);
            #1;
            total++;
            if (q.size() == 0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d_sb: got v=%b qsize=%0d want v=1 qsize>0", i, out_valid, q.size());
                q.delete();
            end else begin
                e = q.pop_front();
                if ({out, borrow, ovf, zero, neg} !== e) begin
                    bad++;
                    $display("FAIL b2b%0d: got out=%b b=%b o=%b z=%b n=%b want out=%b b=%b o=%b z=%b n=%b",
                             i, out, borrow, ovf, zero, neg, e.d, e.b, e.o, e.z, e.n);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: got qsize=%0d v=%b want qsize=0 v=0", q.size(), out_valid);
        end
    endtask

    initial begin
        last = '0;
        test_reset();
        test_directed();
        test_hold();
        test_rst_collision();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
